// File: rtl/gate_pipe_pkg.sv
// Shared definitions for the gate_pipe streaming logic unit.
// Op codes select the bitwise function applied to operands A and B.
package gate_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_ANDN   = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

endpackage

// File: rtl/gate_popcount.sv
// Combinational population count of a WIDTH-bit word.
module gate_popcount
  import gate_pipe_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int ONES_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]  data,
  output logic [ONES_W-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + ONES_W'(data[i]);
    end
  end

endmodule

// File: rtl/gate_pipe.sv
// Two-stage valid/ready pipeline applying a selectable bitwise op to two operands,
// with popcount/zero flags on the result and a completed-transaction counter.
module gate_pipe
  import gate_pipe_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int COUNT_W = 16,
  localparam int ONES_W  = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [OP_W-1:0]    in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic [ONES_W-1:0]  out_ones,
  output logic               out_zero,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] txn_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] op_y;
  logic [ONES_W-1:0] y1_ones;
  logic             s2_ready;
  logic             s1_ready;
  logic             in_fire;
  logic             s1_adv;
  logic             out_fire;

  // Ready is derived only from stage occupancy and out_ready, never in_valid.
  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  assign in_fire  = in_valid && s1_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    op_y = '0;
    case (in_op)
      OP_AND:    op_y = in_a & in_b;
      OP_OR:     op_y = in_a | in_b;
      OP_XOR:    op_y = in_a ^ in_b;
      OP_NAND:   op_y = ~(in_a & in_b);
      OP_NOR:    op_y = ~(in_a | in_b);
      OP_XNOR:   op_y = ~(in_a ^ in_b);
      OP_ANDN:   op_y = in_a & ~in_b;
      OP_PASS_A: op_y = in_a;
      default:   op_y = '0;
    endcase
  end

  gate_popcount #(.WIDTH(WIDTH)) u_popcount (
    .data (y1),
    .ones (y1_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      y1        <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_ones  <= '0;
      out_zero  <= 1'b1;
    end else begin
      // When S1 may move, its next occupancy is exactly whether a new item arrives.
      if (s1_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        y1 <= op_y;
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
      end
      if (s1_adv) begin
        out_y    <= y1;
        out_ones <= y1_ones;
        out_zero <= (y1 == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= '0;
    end else if (cnt_clr) begin
      txn_count <= '0;
    end else if (out_fire) begin
      txn_count <= txn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gate_pipe.sv
// Scoreboard bench for gate_pipe: accepted inputs push expected results,
// output handshakes pop and compare them.
module tb_gate_pipe;
  import gate_pipe_pkg::*;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = 3;
  localparam int ONES_W  = $clog2(WIDTH + 1);

  typedef struct {
    logic [WIDTH-1:0]  y;
    logic [ONES_W-1:0] ones;
    logic              zero;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [OP_W-1:0]    in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_y;
  logic [ONES_W-1:0]  out_ones;
  logic               out_zero;
  logic               cnt_clr;
  logic [COUNT_W-1:0] txn_count;

  int total = 0;
  int bad   = 0;
  int out_fires = 0;
  logic [COUNT_W-1:0] model_cnt = '0;
  exp_t exp_q[$];

  gate_pipe #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_ones  (out_ones),
    .out_zero  (out_zero),
    .cnt_clr   (cnt_clr),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [OP_W-1:0] op);
    exp_t e;
    logic [WIDTH-1:0] y;
    case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XNOR:   y = ~(a ^ b);
      OP_ANDN:   y = a & ~b;
      default:   y = a;
    endcase
    e.y    = y;
    e.ones = ONES_W'($countones(y));
    e.zero = (y == 0);
    return e;
  endfunction

  // Inputs change 1ns after posedge, so the negedge sees what the next edge will see.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      model_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        out_fires++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow got y=%h want no output", out_y);
        end else begin
          e = exp_q.pop_front();
          if ({out_y, out_ones, out_zero} !== {e.y, e.ones, e.zero}) begin
            bad++;
            $display("FAIL sb_result got y=%h ones=%0d zero=%b want y=%h ones=%0d zero=%b",
                     out_y, out_ones, out_zero, e.y, e.ones, e.zero);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op));
      if (cnt_clr) model_cnt = '0;
      else if (out_valid && out_ready) model_cnt = model_cnt + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (out_valid || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic send_stream(input int n);
    int sent = 0;
    int guard = 0;
    logic acc;
    out_ready = 1'b1;
    while (sent < n && guard < 200) begin
      in_valid = 1'b1;
      in_a  = WIDTH'($urandom);
      in_b  = WIDTH'($urandom);
      in_op = OP_W'($urandom);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    total++;
    if (sent != n) begin
      bad++;
      $display("FAIL send_timeout got sent=%0d want %0d", sent, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    #2;
    total++;
    if ({out_valid, out_y, out_ones, out_zero, txn_count} !== {1'b0, 8'h00, 4'd0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL reset_state got v=%b y=%h ones=%0d z=%b cnt=%0d want v=0 y=00 ones=0 z=1 cnt=0",
               out_valid, out_y, out_ones, out_zero, txn_count);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_y [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};
    int         exp_n [8] = '{2, 6, 4, 6, 2, 4, 2, 4};
    out_ready = 1'b1;
    in_a = 8'hF0;
    in_b = 8'hCC;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        in_op = OP_W'(c);
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_y !== exp_y[c-2] || out_ones !== ONES_W'(exp_n[c-2])) begin
          bad++;
          $display("FAIL op_sweep[%0d] got v=%b y=%h ones=%0d want v=1 y=%h ones=%0d",
                   c - 2, out_valid, out_y, out_ones, exp_y[c-2], exp_n[c-2]);
        end
      end
      tick();
    end
    wait_drain();
  endtask

  task automatic single_wait(input logic [7:0] a, input logic [7:0] b, input logic [OP_W-1:0] op);
    int n = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic test_zero_flag();
    single_wait(8'hAA, 8'h55, OP_AND);
    total++;
    if ({out_valid, out_y, out_ones, out_zero} !== {1'b1, 8'h00, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL zero_and got v=%b y=%h ones=%0d z=%b want v=1 y=00 ones=0 z=1",
               out_valid, out_y, out_ones, out_zero);
    end
    single_wait(8'hAA, 8'h55, OP_NAND);
    total++;
    if ({out_valid, out_y, out_ones, out_zero} !== {1'b1, 8'hFF, 4'd8, 1'b0}) begin
      bad++;
      $display("FAIL zero_nand got v=%b y=%h ones=%0d z=%b want v=1 y=ff ones=8 z=0",
               out_valid, out_y, out_ones, out_zero);
    end
    wait_drain();
  endtask

  task automatic test_back_pressure();
    logic [WIDTH-1:0] hold_y;
    logic acc;
    int sent = 0;
    wait_drain();
    clear_count();
    for (int c = 0; c < 40 && !(sent == 5 && c >= 7); c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 5);
      in_a  = WIDTH'(8'h11 * (sent + 1));
      in_b  = WIDTH'(8'h5A ^ sent);
      in_op = OP_W'(sent + 2);
      if (c == 3) hold_y = out_y;
      if (c >= 4 && c <= 6) begin
        total++;
        if (out_valid !== 1'b1 || out_y !== hold_y) begin
          bad++;
          $display("FAIL bp_hold[%0d] got v=%b y=%h want v=1 y=%h", c, out_valid, out_y, hold_y);
        end
      end
      if (c == 4) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    wait_drain();
    total++;
    if (txn_count !== 3'd5) begin
      bad++;
      $display("FAIL bp_count got %0d want 5", txn_count);
    end
  endtask

  task automatic test_counter();
    int n = 0;
    wait_drain();
    clear_count();
    send_stream(9);
    wait_drain();
    total++;
    if (txn_count !== 3'd1) begin
      bad++;
      $display("FAIL cnt_wrap got %0d want 1", txn_count);
    end
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h3C; in_op = OP_XOR;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++;
    if (txn_count !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL cnt_clr_wins got cnt=%0d v=%b want cnt=0 v=0", txn_count, out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    wait_drain();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h96; in_op = OP_OR;
    tick();
    in_a = 8'h7E; in_op = OP_XOR;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre got v=%b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_y, out_zero, txn_count} !== {1'b0, 8'h00, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL midrst_async got v=%b y=%h z=%b cnt=%0d want v=0 y=00 z=1 cnt=0",
               out_valid, out_y, out_zero, txn_count);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_stale[%0d] got v=%b y=%h want v=0", c, out_valid, out_y);
      end
    end
  endtask

  task automatic test_random_soak();
    int sent = 0;
    int guard = 0;
    int base = out_fires;
    logic acc;
    while (sent < 1000 && guard < 10000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a  = WIDTH'($urandom);
      in_b  = WIDTH'($urandom);
      in_op = OP_W'($urandom);
      cnt_clr = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      guard++;
    end
    cnt_clr = 1'b0;
    wait_drain();
    total++;
    if (out_fires - base != 1000 || sent != 1000) begin
      bad++;
      $display("FAIL soak_transfers got in=%0d out=%0d want 1000", sent, out_fires - base);
    end
    total++;
    if (txn_count !== model_cnt) begin
      bad++;
      $display("FAIL soak_count got %0d want %0d", txn_count, model_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_op_sweep();
    test_zero_flag();
    test_back_pressure();
    test_counter();
    test_reset_midflight();
    test_random_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_pipe.md
Name: gate_pipe

Overview:
Parametrised, pipelined successor to the team's single-bit two-input gate block. Applies one of eight selectable bitwise logic operations to two WIDTH-bit operands per transaction. Uses a valid/ready handshake on both sides and a two-stage pipeline with back-pressure. Also reports a population count and zero flag of each result, plus a running count of completed transactions. Sits between a stimulus/source block and any sink that consumes streamed logic results.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
COUNT_W, 16, width of the completed-transaction counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  source presents a transaction
in_ready  output  1  block accepts the transaction this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  operation select
out_valid  output  1  result available
out_ready  input  1  sink accepts the result this cycle
out_y  output  WIDTH  result
out_ones  output  $clog2(WIDTH+1)  number of 1 bits in out_y
out_zero  output  1  high when out_y == 0
cnt_clr  input  1  synchronous clear of txn_count
txn_count  output  COUNT_W  completed output handshakes, modulo 2^COUNT_W

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Operation encoding (in_op):
  - 0 AND, 1 OR, 2 XOR, 3 NAND
  - 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A
  - All eight codes are defined, so no illegal op exists.
- Reset values: all internal valid flags 0; out_valid 0; out_y 0; out_ones 0; out_zero 1; txn_count 0. in_ready is 1 one cycle after rst deasserts, since it is combinational from empty stages.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Stage 1 (S1): on input transfer, register y1 = op(in_a, in_b) and set s1_valid.
- Stage 2 (S2): when S1 advances, register out_y = y1, out_ones = popcount(y1), out_zero = (y1 == 0), and set out_valid.
- Ready chain:
  - s2_ready = !out_valid | out_ready
  - s1_ready = !s1_valid | s2_ready
  - in_ready = s1_ready
  - in_ready must not depend on in_valid (no combinational loop).
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Throughput: one transaction per cycle.
- Back-pressure:
  - While out_valid & !out_ready, out_y, out_ones and out_zero hold stable.
  - S1 holds its data when S2 is full and stalled; in_ready then drops.
  - Maximum two transactions in flight. No data is dropped or duplicated.
- Simultaneous events: with both stages full and out_ready=1, the output, S1 and input transfers all occur in the same cycle.
- Flag rules: out_zero is valid even when out_valid=0 (it tracks out_y). out_ones width is $clog2(WIDTH+1); for WIDTH=1 it is 1 bit.
- Counter:
  - txn_count increments by 1 on each output transfer and wraps from 2^COUNT_W-1 to 0.
  - If cnt_clr and an output transfer occur in the same cycle, clear wins and txn_count = 0.
  - cnt_clr does not affect the pipeline.
- Reset mid-operation: asserting rst discards in-flight transactions immediately (asynchronously) and returns all outputs to reset values. No partial result appears after release.
- in_op is sampled only at input transfer. Changes while in_ready=0 have no effect.

Decomposition:
- Shared package gate_pipe_pkg: the eight op-code localparams (OP_AND .. OP_PASS_A) and the op-width constant (3). The testbench's reference model uses the same package.
- One sub-module, gate_popcount: parametrised on WIDTH, purely combinational, computes out_ones for S2.
- The op mux lives inline in gate_pipe.

Test Plan:
- Op sweep (WIDTH=8): a=8'hF0, b=8'hCC, out_ready=1, op 0..7 back-to-back. Expect out_y = C0, FC, 3C, 3F, 03, C3, 30, F0 on consecutive cycles starting 2 cycles after the first accept; out_ones = 2, 6, 4, 6, 2, 4, 2, 4.
- Zero flag: op=AND, a=8'hAA, b=8'h55. Expect out_y=00, out_zero=1, out_ones=0. Then op=NAND on the same operands: out_y=FF, out_ones=8, out_zero=0.
- Back-pressure: stream 5 transactions with out_ready=0 for cycles 3-6. Expect in_ready=0 once 2 are in flight, out_y stable during the stall, all 5 results delivered in order, txn_count=5.
- Counter wrap/clear (COUNT_W=3): 9 output transfers, expect txn_count=1. Assert cnt_clr in the same cycle as the 10th transfer, expect txn_count=0.
- Reset mid-flight: accept 2 transactions, assert rst for 1 cycle before either is output. Expect out_valid=0, out_y=0, out_zero=1, txn_count=0 immediately, and no stale result afterwards.
- Random soak: 1000 random a/b/op with random in_valid/out_ready. Scoreboard against the package-based model; zero mismatches, and txn_count equals the number of output transfers.
